// File: rtl/cache_pkg.sv
// Shared definitions for the N-way cache controller: FSM state encoding,
// default geometry and the index-width helper used by the top and the LRU block.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_WRITEBACK,
        ST_FILL,
        ST_RESPOND
    } state_t;

    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_WAYS    = 2;
    localparam int DEF_SETS    = 4;
    localparam int DEF_COUNT_W = 8;

    // Width of an index selecting one of n items; never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lru_nvias.sv
// True-LRU age tracker: one age per way per set, kept as a permutation of
// 0..WAYS-1. The most recently used way has age 0, the victim has the maximum age.
module lru_nvias
    import cache_pkg::*;
#(
    parameter  int WAYS  = DEF_WAYS,
    parameter  int SETS  = DEF_SETS,
    localparam int WAY_W = idx_bits(WAYS),
    localparam int IDX_W = idx_bits(SETS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] i_index,
    input  logic             i_access_valid,
    input  logic [WAY_W-1:0] i_access_way,
    output logic [WAY_W-1:0] o_victim
);

    logic [WAY_W-1:0] r_age [SETS][WAYS];
    logic [WAY_W-1:0] w_acc_age;
    logic [WAY_W-1:0] w_max_age;

    assign w_acc_age = r_age[i_index][i_access_way];

    always_comb begin
        o_victim  = '0;
        w_max_age = r_age[i_index][0];
        for (int w = 1; w < WAYS; w++) begin
            if (r_age[i_index][w] > w_max_age) begin
                w_max_age = r_age[i_index][w];
                o_victim  = WAY_W'(w);
            end
        end
    end

    // Ways younger than the touched one age by one; the touched way becomes youngest.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= WAY_W'(w);
                end
            end
        end else if (i_access_valid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == i_access_way) begin
                    r_age[i_index][w] <= '0;
                end else if (r_age[i_index][w] < w_acc_age) begin
                    r_age[i_index][w] <= r_age[i_index][w] + WAY_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cache_nvias.sv
// N-way set-associative write-back / write-allocate cache controller with a
// req/ack backing-memory port, true-LRU replacement and saturating hit/miss counters.
module cache_nvias
    import cache_pkg::*;
#(
    parameter  int ADDR_W  = DEF_ADDR_W,
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int WAYS    = DEF_WAYS,
    parameter  int SETS    = DEF_SETS,
    parameter  int COUNT_W = DEF_COUNT_W,
    localparam int IDX_W   = idx_bits(SETS),
    localparam int TAG_W   = ADDR_W - IDX_W,
    localparam int WAY_W   = idx_bits(WAYS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cpu_valid,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_ready,
    output logic               cpu_done,
    output logic               cpu_hit,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               cpu_dirty,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] miss_count
);

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [WAY_W-1:0]    r_vway;
    logic [TAG_W-1:0]    r_vtag;
    logic [DATA_W-1:0]   r_vdata;
    logic                r_hit;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_dirty_out;
    logic [COUNT_W-1:0]  r_hit_cnt;
    logic [COUNT_W-1:0]  r_miss_cnt;
    logic [SETS-1:0]     r_valid [WAYS];
    logic [SETS-1:0]     r_dirty [WAYS];

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_rd_idx;
    logic                w_accept;
    logic [TAG_W-1:0]    w_tag_rd  [WAYS];
    logic [DATA_W-1:0]   w_data_rd [WAYS];
    logic [WAYS-1:0]     w_tag_we;
    logic [WAYS-1:0]     w_data_we;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way;
    logic [WAY_W-1:0]    w_victim;
    logic                w_found_invalid;
    logic                w_victim_dirty;
    logic                w_fill_ack;
    logic                w_lru_valid;
    logic [WAY_W-1:0]    w_lru_way;
    logic [WAY_W-1:0]    w_lru_victim;

    assign w_idx      = r_addr[IDX_W-1:0];
    assign w_tag      = r_addr[ADDR_W-1:IDX_W];
    assign w_rd_idx   = cpu_addr[IDX_W-1:0];
    assign w_accept   = cpu_valid && (r_state == ST_IDLE);
    assign w_fill_ack = (r_state == ST_FILL) && mem_ack;

    // Tag/data storage per way; the read port is registered on the accept edge
    // so COMPARE sees the whole set without a combinational array read.
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [TAG_W-1:0]  r_tag_mem  [SETS];
        logic [DATA_W-1:0] r_data_mem [SETS];
        logic [TAG_W-1:0]  r_tag_q;
        logic [DATA_W-1:0] r_data_q;

        always_ff @(posedge clock) begin
            if (w_tag_we[gi]) begin
                r_tag_mem[w_idx] <= w_tag;
            end
            if (w_data_we[gi]) begin
                r_data_mem[w_idx] <= w_wr_data;
            end
            if (w_accept) begin
                r_tag_q  <= r_tag_mem[w_rd_idx];
                r_data_q <= r_data_mem[w_rd_idx];
            end
        end

        assign w_tag_rd[gi]  = r_tag_q;
        assign w_data_rd[gi] = r_data_q;
    end

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && (w_tag_rd[w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    // Empty ways are filled lowest-index first before LRU eviction kicks in.
    always_comb begin
        w_victim        = w_lru_victim;
        w_found_invalid = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found_invalid && !r_valid[w][w_idx]) begin
                w_found_invalid = 1'b1;
                w_victim        = WAY_W'(w);
            end
        end
    end

    assign w_victim_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];

    always_comb begin
        w_tag_we    = '0;
        w_data_we   = '0;
        w_wr_data   = r_wdata;
        w_lru_valid = 1'b0;
        w_lru_way   = w_hit_way;
        if ((r_state == ST_COMPARE) && w_hit) begin
            w_lru_valid = 1'b1;
            if (r_we) begin
                w_data_we[w_hit_way] = 1'b1;
            end
        end
        if (w_fill_ack) begin
            w_tag_we[r_vway]  = 1'b1;
            w_data_we[r_vway] = 1'b1;
            w_wr_data         = r_we ? r_wdata : mem_rdata;
            w_lru_valid       = 1'b1;
            w_lru_way         = r_vway;
        end
    end

    lru_nvias #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clock          (clock),
        .reset          (reset),
        .i_index        (w_idx),
        .i_access_valid (w_lru_valid),
        .i_access_way   (w_lru_way),
        .o_victim       (w_lru_victim)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (cpu_valid) w_state_next = ST_COMPARE;
            ST_COMPARE:   w_state_next = w_hit ? ST_RESPOND :
                                         (w_victim_dirty ? ST_WRITEBACK : ST_FILL);
            ST_WRITEBACK: if (mem_ack) w_state_next = ST_FILL;
            ST_FILL:      if (mem_ack) w_state_next = ST_RESPOND;
            ST_RESPOND:   w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_vway      <= '0;
            r_vtag      <= '0;
            r_vdata     <= '0;
            r_hit       <= 1'b0;
            r_rdata     <= '0;
            r_dirty_out <= 1'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_valid) begin
                        r_addr  <= cpu_addr;
                        r_we    <= cpu_we;
                        r_wdata <= cpu_wdata;
                    end
                end
                ST_COMPARE: begin
                    if (w_hit) begin
                        r_hit       <= 1'b1;
                        r_rdata     <= r_we ? r_wdata : w_data_rd[w_hit_way];
                        r_dirty_out <= r_we | r_dirty[w_hit_way][w_idx];
                        if (r_we) begin
                            r_dirty[w_hit_way][w_idx] <= 1'b1;
                        end
                        if (r_hit_cnt != '1) begin
                            r_hit_cnt <= r_hit_cnt + COUNT_W'(1);
                        end
                    end else begin
                        r_vway  <= w_victim;
                        r_vtag  <= w_tag_rd[w_victim];
                        r_vdata <= w_data_rd[w_victim];
                        if (r_miss_cnt != '1) begin
                            r_miss_cnt <= r_miss_cnt + COUNT_W'(1);
                        end
                    end
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        r_valid[r_vway][w_idx] <= 1'b1;
                        r_dirty[r_vway][w_idx] <= r_we;
                        r_hit                  <= 1'b0;
                        r_rdata                <= w_wr_data;
                        r_dirty_out            <= r_we;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_ready  = (r_state == ST_IDLE);
    assign cpu_done   = (r_state == ST_RESPOND);
    assign cpu_hit    = r_hit;
    assign cpu_rdata  = r_rdata;
    assign cpu_dirty  = r_dirty_out;
    assign mem_req    = (r_state == ST_WRITEBACK) || (r_state == ST_FILL);
    assign mem_we     = (r_state == ST_WRITEBACK);
    assign mem_addr   = (r_state == ST_WRITEBACK) ? {r_vtag, w_idx} :
                        (r_state == ST_FILL)      ? r_addr : '0;
    assign mem_wdata  = (r_state == ST_WRITEBACK) ? r_vdata : '0;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

endmodule

// File: tb/tb_cache_nvias.sv
// Directed bench for cache_nvias: a default-geometry instance plus a COUNT_W=4
// instance sharing the same stimulus to observe counter saturation.
module tb_cache_nvias;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_valid = 1'b0;
    logic       cpu_we = 1'b0;
    logic [4:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic [7:0] mem_rdata = '0;
    logic       mem_ack = 1'b0;

    logic       cpu_ready, cpu_done, cpu_hit, cpu_dirty, mem_req, mem_we;
    logic [7:0] cpu_rdata, mem_wdata, hit_count, miss_count;
    logic [4:0] mem_addr;

    logic       s_ready, s_done, s_hit, s_dirty, s_req, s_we;
    logic [7:0] s_rdata, s_wdata;
    logic [4:0] s_addr;
    logic [3:0] s_hit_count, s_miss_count;

    always #5 clk = ~clk;

    cache_nvias dut (
        .clock(clk), .reset(rst),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_hit(cpu_hit),
        .cpu_rdata(cpu_rdata), .cpu_dirty(cpu_dirty),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_nvias #(.COUNT_W(4)) dut_sat (
        .clock(clk), .reset(rst),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(s_ready), .cpu_done(s_done), .cpu_hit(s_hit),
        .cpu_rdata(s_rdata), .cpu_dirty(s_dirty),
        .mem_req(s_req), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    int         n_checks = 0;
    int         n_pass   = 0;

    // Results of the most recent access.
    logic       res_hit, res_dirty;
    logic [7:0] res_rdata;
    int         res_lat, n_txn, unstable, first_req_k, req_gap;
    logic       log_we    [4];
    logic [4:0] log_addr  [4];
    logic [7:0] log_wdata [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One CPU access; the memory side acks each transaction ack_dly cycles after it appears.
    task automatic run_access(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                              input int ack_dly, input logic [7:0] fill);
        int wait_c;
        bit got;
        wait_c = 0; got = 0; n_txn = 0; unstable = 0; first_req_k = 0; req_gap = 0; res_lat = 0;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        cpu_valid = 1'b0;
        for (int k = 1; k <= 200 && !got; k++) begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                n_txn++;
                wait_c = 0;
            end
            if (cpu_done) begin
                got       = 1;
                res_lat   = k;
                res_hit   = cpu_hit;
                res_rdata = cpu_rdata;
                res_dirty = cpu_dirty;
            end else begin
                if (mem_req) begin
                    if (first_req_k == 0) first_req_k = k;
                    if (n_txn < 4) begin
                        if (wait_c == 0) begin
                            log_we[n_txn] = mem_we; log_addr[n_txn] = mem_addr; log_wdata[n_txn] = mem_wdata;
                        end else if (mem_we !== log_we[n_txn] || mem_addr !== log_addr[n_txn]
                                     || mem_wdata !== log_wdata[n_txn]) begin
                            unstable++;
                        end
                    end
                    if (wait_c == ack_dly) begin
                        mem_ack   = 1'b1;
                        mem_rdata = fill;
                    end
                    wait_c++;
                end else if (first_req_k != 0) begin
                    req_gap++;
                end
                @(negedge clk);
            end
        end
        if (!got) check_eq("done_timeout", 32'd0, 32'd1);
        $display("access we=%0d addr=0x%02h wdata=0x%02h -> hit=%0d rdata=0x%02h dirty=%0d lat=%0d mem_txns=%0d",
                 we, addr, wdata, res_hit, res_rdata, res_dirty, res_lat, n_txn);
    endtask

    initial begin
        int hits_seen;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", cpu_ready, 1);
        check_eq("rst_done", cpu_done, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_rdata", cpu_rdata, 0);
        check_eq("rst_miss_count", miss_count, 0);
        rst = 1'b0;

        // Cold read miss
        run_access(1'b0, 5'h05, 8'h00, 3, 8'hA7);
        check_eq("cold_hit", res_hit, 0);
        check_eq("cold_rdata", res_rdata, 8'hA7);
        check_eq("cold_txns", n_txn, 1);
        check_eq("cold_fill_we", log_we[0], 0);
        check_eq("cold_fill_addr", log_addr[0], 5'h05);
        check_eq("cold_req_start", first_req_k, 2);
        check_eq("cold_miss_count", miss_count, 1);

        // Re-read hit
        run_access(1'b0, 5'h05, 8'h00, 0, 8'h00);
        check_eq("reread_hit", res_hit, 1);
        check_eq("reread_lat", res_lat, 2);
        check_eq("reread_rdata", res_rdata, 8'hA7);
        check_eq("reread_txns", n_txn, 0);

        // Write hit
        run_access(1'b1, 5'h05, 8'h3C, 0, 8'h00);
        check_eq("wrhit_hit", res_hit, 1);
        check_eq("wrhit_dirty", res_dirty, 1);
        check_eq("wrhit_rdata", res_rdata, 8'h3C);
        check_eq("wrhit_txns", n_txn, 0);
        run_access(1'b0, 5'h05, 8'h00, 0, 8'h00);
        check_eq("rd_after_wr", res_rdata, 8'h3C);
        check_eq("hit_count_3", hit_count, 3);

        // Second line in set 1 goes to the empty way
        run_access(1'b0, 5'h09, 8'h00, 1, 8'h11);
        check_eq("fill09_txns", n_txn, 1);
        check_eq("fill09_rdata", res_rdata, 8'h11);
        check_eq("fill09_dirty", res_dirty, 0);

        // Third line evicts the dirty LRU line 0x05
        run_access(1'b0, 5'h0D, 8'h00, 2, 8'h5D);
        check_eq("evict_txns", n_txn, 2);
        check_eq("evict_wb_we", log_we[0], 1);
        check_eq("evict_wb_addr", log_addr[0], 5'h05);
        check_eq("evict_wb_data", log_wdata[0], 8'h3C);
        check_eq("evict_fill_we", log_we[1], 0);
        check_eq("evict_fill_addr", log_addr[1], 5'h0D);
        check_eq("evict_req_gap", req_gap, 0);
        check_eq("evict_rdata", res_rdata, 8'h5D);
        run_access(1'b0, 5'h09, 8'h00, 0, 8'h00);
        check_eq("keep09_hit", res_hit, 1);
        check_eq("keep09_rdata", res_rdata, 8'h11);

        // Write miss allocate with a slow memory
        run_access(1'b1, 5'h02, 8'h77, 10, 8'h00);
        check_eq("wrmiss_hit", res_hit, 0);
        check_eq("wrmiss_rdata", res_rdata, 8'h77);
        check_eq("wrmiss_dirty", res_dirty, 1);
        check_eq("wrmiss_fill_addr", log_addr[0], 5'h02);
        check_eq("wrmiss_stable", unstable, 0);
        run_access(1'b0, 5'h02, 8'h00, 0, 8'h00);
        check_eq("rd02_hit", res_hit, 1);
        check_eq("rd02_rdata", res_rdata, 8'h77);
        check_eq("counts_hit", hit_count, 5);
        check_eq("counts_miss", miss_count, 4);

        // Spurious ack while idle
        @(negedge clk); mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("spur_ready", cpu_ready, 1);
        check_eq("spur_req", mem_req, 0);
        check_eq("spur_done", cpu_done, 0);
        check_eq("spur_miss", miss_count, 4);
        mem_ack = 1'b0;

        // Reset during FILL
        @(negedge clk); cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h15;
        @(negedge clk); cpu_valid = 1'b0;
        @(negedge clk);
        check_eq("prerst_req", mem_req, 1);
        check_eq("prerst_miss", miss_count, 5);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_req", mem_req, 0);
        check_eq("midrst_ready", cpu_ready, 1);
        check_eq("midrst_hits", hit_count, 0);
        check_eq("midrst_miss", miss_count, 0);
        @(negedge clk); rst = 1'b0;
        $display("reset pulsed during FILL of 0x15");
        run_access(1'b0, 5'h05, 8'h00, 0, 8'hA7);
        check_eq("postrst_hit", res_hit, 0);
        check_eq("postrst_miss", miss_count, 1);

        // Saturation in the 4-bit counter instance
        hits_seen = 0;
        for (int i = 0; i < 20; i++) begin
            run_access(1'b0, 5'h05, 8'h00, 0, 8'h00);
            if (res_hit) hits_seen++;
        end
        check_eq("sat_hits_seen", hits_seen, 20);
        check_eq("wide_hit_count", hit_count, 20);
        check_eq("sat_hit_count", s_hit_count, 4'hF);
        check_eq("sat_miss_count", s_miss_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_nvias.md
# cache_nvias

Parametrised N-way set-associative, write-back, write-allocate cache controller; the successor of the fixed 2-way `cache2vias`. Sits between the board-level test top (switches/keys as CPU side, HEX/LED display) and a word-addressed backing memory, which it reaches through a req/ack handshake. Replacement is true LRU per set. Saturating hit/miss counters are provided for display.

## Interface
- `ADDR_W`, 5: word address width.
- `DATA_W`, 8: data word width; one word per line.
- `WAYS`, 2: associativity; power of two, ≥2.
- `SETS`, 4: number of sets; power of two, ≥2. `IDX_W = log2(SETS)`, `TAG_W = ADDR_W - IDX_W` (≥1).
- `COUNT_W`, 8: hit/miss counter width.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_valid` in 1: request strobe; accepted on an edge where `cpu_ready`=1.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: index = `[IDX_W-1:0]`, tag = upper bits.
- `cpu_wdata` in DATA_W: write data.
- `cpu_ready` out 1: idle, can accept. Reset 1.
- `cpu_done` out 1: one-cycle completion pulse. Reset 0.
- `cpu_hit` out 1: valid with `cpu_done`; 1 = hit. Reset 0.
- `cpu_rdata` out DATA_W: read data, valid with `cpu_done`. Reset 0.
- `cpu_dirty` out 1: dirty bit of the accessed line after completion (LED). Reset 0.
- `mem_req` out 1: memory request. Reset 0.
- `mem_we` out 1: 1 = write-back, 0 = fill. Reset 0.
- `mem_addr` out ADDR_W: memory word address. Reset 0.
- `mem_wdata` out DATA_W: write-back data. Reset 0.
- `mem_rdata` in DATA_W: fill data, sampled on the ack edge.
- `mem_ack` in 1: transfer complete on an edge where `mem_req`=1 and `mem_ack`=1.
- `hit_count`, `miss_count` out COUNT_W: saturating counters. Reset 0.

## Operation
- Per way and set: valid, dirty, tag, data, LRU age (`log2(WAYS)` bits).
- Reset state: all valid and dirty bits 0; ages initialised to the way index.
- FSM states:
  - IDLE: `cpu_ready`=1. An accepted request latches addr/we/wdata and moves to COMPARE.
  - COMPARE, hit (valid and tag equal in exactly one way): a write stores `cpu_wdata` and sets dirty; a read returns the data. LRU is updated. Goes to RESPOND with hit=1 and increments `hit_count`.
  - COMPARE, miss: increments `miss_count`. Victim is the lowest-index invalid way, or else the way with the maximum age. A dirty victim goes to WRITEBACK; otherwise to FILL.
  - WRITEBACK: `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag, index}, `mem_wdata`=victim data. On ack, go to FILL.
  - FILL: `mem_req`=1, `mem_we`=0, `mem_addr`=request address. On ack:
    - install the tag, set valid, and load `mem_rdata`;
    - a write miss then overwrites the data with `cpu_wdata` and sets dirty=1; a read leaves dirty=0;
    - LRU is updated and the FSM goes to RESPOND with hit=0.
  - RESPOND: `cpu_done`=1 and `cpu_ready`=0, then IDLE.
- LRU update on access to way w with age a: every way with age < a increments; w gets 0. Ages stay a permutation of 0..WAYS-1.
- `cpu_rdata` returns the line data after the access (write data for writes).
- Counters saturate at all-ones; they do not wrap.
- `cpu_valid` while `cpu_ready`=0 is ignored.
- `mem_ack` while `mem_req`=0 is ignored.

## Timing
- All outputs are registered or decoded from registered state.
- Hit: accept edge E0; COMPARE during E0..E1; `cpu_done` high E1..E2. `cpu_ready` returns at E2. Hit latency is 2 cycles.
- Miss (clean): `mem_req` rises after E1. `cpu_done` rises the cycle after the fill ack edge.
- Miss (dirty): adds one write-back transaction. `mem_req` deasserts for zero cycles between write-back and fill (re-issued with `mem_we`=0).
- `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` are held stable until the ack edge; ack latency is unbounded.
- Reset asserted mid-operation, any state: immediately FSM→IDLE, `mem_req`=0, `cpu_done`=0, all lines invalid, counters 0. A pending memory transaction is abandoned.

## Structure
- A shared package `cache_pkg` holds the state enum (IDLE, COMPARE, WRITEBACK, FILL, RESPOND) and the `clog2`-derived width constants.
- One sub-module, `lru_nvias`, holds the per-set age array with ports: index, access valid, way, victim (max-age way) output. The top instantiates it once.

## Test plan
Defaults apply (WAYS=2, SETS=4, ADDR_W=5, DATA_W=8, COUNT_W=8).
- Cold read miss: after reset, read 0x05 → FILL `mem_addr`=0x05; ack after 3 cycles with `mem_rdata`=0xA7 → done, hit=0, rdata=0xA7, miss_count=1. Re-read 0x05 → done 2 cycles after accept, hit=1, rdata=0xA7, no `mem_req`.
- Write hit: write 0x05 ← 0x3C → hit=1, `cpu_dirty`=1, no memory traffic. Read 0x05 → 0x3C.
- Dirty LRU eviction in set 1: read 0x09 (fill 0x11), then read 0x0D. Victim is the 0x05 line → WRITEBACK with `mem_addr`=0x05, `mem_wdata`=0x3C, then FILL 0x0D. The line 0x09 stays resident (re-read hits).
- Write miss allocate: write 0x02 ← 0x77, fill returns 0x00 → rdata=0x77, dirty=1, hit=0. Read 0x02 → hit, 0x77.
- Handshake stability: ack delayed 10 cycles → `mem_req`/`mem_addr`/`mem_we` constant throughout. Spurious `mem_ack` while IDLE → no state change.
- Reset mid-FILL: `mem_req` drops in the same cycle, `cpu_ready`=1, counters 0. Read 0x05 → miss. With COUNT_W=4, 20 hits → `hit_count`=15.
